// File: rtl/ro_request_sequencer.sv
// ro_request_sequencer
//
// Queues L1 readout requests and hands them to the readout engine one at a
// time. It sits directly in front of the local L0ID hold register.
// Each request carries the L0ID it asks for. It is held in a small FIFO.
// The FIFO head is issued to the readout engine with a start/ready/done
// handshake. When a readout finishes, the block sends a one-cycle strobe
// that advances the local L0ID.
//
// Ports
//   CLK           system clock, all logic on posedge
//   SoftReset     synchronous, active-high reset (priority over all inputs)
//   L1Req         single-cycle readout request strobe
//   L1ReqL0ID     L0ID of the request, sampled with L1Req
//   L0ID_Local    current value of the local L0ID hold register
//   ROReady       readout engine idle and able to accept a start
//   RODone        single-cycle pulse: current readout finished
//   ClearFlags    clears the sticky flags (a same-cycle set wins)
//   ROStart       single-cycle start pulse to the readout engine
//   ROL0ID        L0ID of the event being read, held until the next ROStart
//   ROReadStrob   single-cycle increment pulse to the local L0ID register
//   QueueEmpty    FIFO holds no requests
//   QueueFull     FIFO holds FIFO_DEPTH requests
//   QueueCount    number of queued requests
//   Overflow      sticky: a request was dropped because the FIFO was full
//   L0IDMismatch  sticky: a started L0ID differed from L0ID_Local
//
// Optional feature: define L0ID_CHECK_EN to compare the FIFO head with
// L0ID_Local when each event starts. Without the macro, L0IDMismatch is
// tied low and no comparator is built.

module ro_request_sequencer #(
    parameter int RO_ADDR_WIDTH = 8,
    parameter int FIFO_DEPTH    = 8,
    parameter int PTR_WIDTH     = 3
) (
    input  logic                     CLK,
    input  logic                     SoftReset,
    input  logic                     L1Req,
    input  logic [RO_ADDR_WIDTH-1:0] L1ReqL0ID,
    input  logic [RO_ADDR_WIDTH-1:0] L0ID_Local,
    input  logic                     ROReady,
    input  logic                     RODone,
    input  logic                     ClearFlags,
    output logic                     ROStart,
    output logic [RO_ADDR_WIDTH-1:0] ROL0ID,
    output logic                     ROReadStrob,
    output logic                     QueueEmpty,
    output logic                     QueueFull,
    output logic [PTR_WIDTH:0]       QueueCount,
    output logic                     Overflow,
    output logic                     L0IDMismatch
);

    typedef enum logic [1:0] {IDLE, START, WAIT_DONE, STROBE} state_t;

    localparam logic [PTR_WIDTH:0] DEPTH_C = FIFO_DEPTH[PTR_WIDTH:0];

    state_t                   state, state_nxt;
    logic [RO_ADDR_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]     wr_ptr, rd_ptr;
    logic [PTR_WIDTH:0]       count_nxt;
    logic                     full, push, pop, drop;
    logic                     load_head, start_nxt, strobe_nxt, mismatch_set;

    assign full = (QueueCount == DEPTH_C);

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt  = state;
        load_head  = 1'b0;
        start_nxt  = 1'b0;
        strobe_nxt = 1'b0;
        pop        = 1'b0;
        unique case (state)
            IDLE: begin
                if ((QueueCount != '0) && ROReady) begin
                    state_nxt = START;
                    load_head = 1'b1;
                    start_nxt = 1'b1;
                end
            end
            START: begin
                // The head was copied into ROL0ID on entry, so its slot can be freed now.
                pop       = 1'b1;
                state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (RODone) begin
                    state_nxt  = STROBE;
                    strobe_nxt = 1'b1;
                end
            end
            STROBE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A full FIFO still accepts a request in the cycle that frees a slot.
    assign push = L1Req && (!full || pop);
    assign drop = L1Req && full && !pop;

    always_comb begin
        count_nxt = QueueCount;
        unique case ({push, pop})
            2'b10:   count_nxt = QueueCount + 1'b1;
            2'b01:   count_nxt = QueueCount - 1'b1;
            default: count_nxt = QueueCount;
        endcase
    end

`ifdef L0ID_CHECK_EN
    assign mismatch_set = load_head && (fifo_mem[rd_ptr] != L0ID_Local);
`else
    logic unused_l0id_local;
    assign unused_l0id_local = ^L0ID_Local;
    assign mismatch_set      = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (SoftReset) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            QueueCount   <= '0;
            QueueEmpty   <= 1'b1;
            QueueFull    <= 1'b0;
            ROStart      <= 1'b0;
            ROReadStrob  <= 1'b0;
            ROL0ID       <= '0;
            Overflow     <= 1'b0;
            L0IDMismatch <= 1'b0;
        end else begin
            state       <= state_nxt;
            ROStart     <= start_nxt;
            ROReadStrob <= strobe_nxt;
            if (load_head) ROL0ID <= fifo_mem[rd_ptr];
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            QueueCount   <= count_nxt;
            QueueEmpty   <= (count_nxt == '0);
            QueueFull    <= (count_nxt == DEPTH_C);
            Overflow     <= drop || (Overflow && !ClearFlags);
            L0IDMismatch <= mismatch_set || (L0IDMismatch && !ClearFlags);
        end
    end

    // NOTE: the storage array has no reset; the pointers and count decide which entries are valid.
    always_ff @(posedge CLK) begin
        if (!SoftReset && push) fifo_mem[wr_ptr] <= L1ReqL0ID;
    end

endmodule

// File: tb/tb_ro_request_sequencer.sv
module tb_ro_request_sequencer;

    logic       CLK = 1'b0;
    logic       SoftReset, L1Req, ROReady, RODone, ClearFlags;
    logic [7:0] L1ReqL0ID, L0ID_Local;
    logic       ROStart, ROReadStrob, QueueEmpty, QueueFull, Overflow, L0IDMismatch;
    logic [7:0] ROL0ID;
    logic [3:0] QueueCount;

    int errors = 0;
    int checks = 0;
    int strobe_seen = 0;
    int strobe_exp  = 0;
    logic [7:0] sb[$];

`ifdef L0ID_CHECK_EN
    localparam logic EXP_MM = 1'b1;
`else
    localparam logic EXP_MM = 1'b0;
`endif

    ro_request_sequencer dut (
        .CLK(CLK), .SoftReset(SoftReset), .L1Req(L1Req), .L1ReqL0ID(L1ReqL0ID),
        .L0ID_Local(L0ID_Local), .ROReady(ROReady), .RODone(RODone),
        .ClearFlags(ClearFlags), .ROStart(ROStart), .ROL0ID(ROL0ID),
        .ROReadStrob(ROReadStrob), .QueueEmpty(QueueEmpty), .QueueFull(QueueFull),
        .QueueCount(QueueCount), .Overflow(Overflow), .L0IDMismatch(L0IDMismatch)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: outputs are sampled 1 time unit after the edge, inputs driven there too.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_start"},  ROStart, 1'b0);
        check({tag, "_strob"},  ROReadStrob, 1'b0);
        check({tag, "_l0id"},   ROL0ID, 8'h00);
        check({tag, "_empty"},  QueueEmpty, 1'b1);
        check({tag, "_full"},   QueueFull, 1'b0);
        check({tag, "_count"},  QueueCount, 4'd0);
        check({tag, "_ovf"},    Overflow, 1'b0);
        check({tag, "_mm"},     L0IDMismatch, 1'b0);
    endtask

    task automatic request(input logic [7:0] id);
        L1Req     = 1'b1;
        L1ReqL0ID = id;
        sb.push_back(id);
    endtask

    // Waits (bounded) for ROStart; leaves the bench in the ROStart cycle.
    task automatic wait_start(input string tag, output int n);
        n = 0;
        while (!ROStart && n < 20) begin
            step();
            n++;
        end
        check(tag, ROStart, 1'b1);
    endtask

    // Scoreboard: each ROStart must carry the oldest outstanding request.
    always @(negedge CLK) begin
        if (ROReadStrob) strobe_seen++;
        if (ROStart) begin
            if (sb.size() == 0) begin
                check("start_without_request", 32'd1, 32'd0);
            end else begin
                check("rol0id_order", ROL0ID, sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int n;
        SoftReset = 1'b1; L1Req = 1'b0; L1ReqL0ID = '0; L0ID_Local = '0;
        ROReady = 1'b0; RODone = 1'b0; ClearFlags = 1'b0;
        step(); step();
        check_reset_state("reset");
        SoftReset = 1'b0;

        // Single request: L1Req in cycle 0, ROStart in cycle 2, RODone at 6, strobe at 7.
        ROReady = 1'b1;
        request(8'h00);
        step();                                    // cycle 1
        L1Req = 1'b0;
        check("single_count1", QueueCount, 4'd1);
        check("single_nostart_c1", ROStart, 1'b0);
        step();                                    // cycle 2
        check("single_start_c2", ROStart, 1'b1);
        check("single_rol0id", ROL0ID, 8'h00);
        step();                                    // cycle 3
        check("single_start_1cyc", ROStart, 1'b0);
        check("single_empty", QueueEmpty, 1'b1);
        step(); step(); step();                    // cycle 6
        check("single_no_early_strob", ROReadStrob, 1'b0);
        RODone = 1'b1;
        step();                                    // cycle 7
        RODone = 1'b0;
        strobe_exp++;
        check("single_strob_c7", ROReadStrob, 1'b1);
        step();                                    // cycle 8
        check("single_strob_1cyc", ROReadStrob, 1'b0);
        check("single_empty_after", QueueEmpty, 1'b1);

        // Burst of 8 while the engine is busy, then a 9th that must be dropped.
        ROReady = 1'b0;
        for (int i = 0; i < 8; i++) begin
            request(8'h10 + 8'(i));
            step();
        end
        check("burst_full", QueueFull, 1'b1);
        check("burst_count8", QueueCount, 4'd8);
        check("burst_no_ovf_yet", Overflow, 1'b0);
        L1Req = 1'b1; L1ReqL0ID = 8'h99;           // dropped: not in the scoreboard
        step();
        L1Req = 1'b0;
        check("ovf_set", Overflow, 1'b1);
        check("ovf_count8", QueueCount, 4'd8);
        check("ovf_full", QueueFull, 1'b1);
        ClearFlags = 1'b1;
        ROReady = 1'b1;
        step();                                    // START for 0x10
        ClearFlags = 1'b0;
        check("ovf_cleared", Overflow, 1'b0);
        check("drain_start0", ROStart, 1'b1);

        // Push during the START cycle while full: accepted, count stays 8.
        request(8'h20);
        step();
        L1Req = 1'b0;
        check("pushpop_no_ovf", Overflow, 1'b0);
        check("pushpop_count8", QueueCount, 4'd8);
        check("pushpop_full", QueueFull, 1'b1);

        // Drain 9 events; the next start follows the strobe by exactly 2 cycles.
        for (int e = 0; e < 9; e++) begin
            if (e > 0) begin
                wait_start("drain_start", n);
                check("drain_gap", n, 2);
                step();
            end
            RODone = 1'b1;
            step();
            RODone = 1'b0;
            strobe_exp++;
            check("drain_strob", ROReadStrob, 1'b1);
        end
        step(); step(); step();
        check("drain_empty", QueueEmpty, 1'b1);
        check("drain_sb_empty", sb.size(), 0);
        check("drain_strobes", strobe_seen, strobe_exp);

        // Spurious RODone in IDLE, then in START.
        RODone = 1'b1;
        step();
        RODone = 1'b0;
        check("spur_idle_strob", ROReadStrob, 1'b0);
        check("spur_idle_nostart", ROStart, 1'b0);
        request(8'h30);
        step();
        L1Req = 1'b0;
        step();
        check("spur_start", ROStart, 1'b1);
        RODone = 1'b1;                             // in START: ignored
        step();
        RODone = 1'b0;
        check("spur_start_strob", ROReadStrob, 1'b0);
        step();
        check("spur_wait_strob", ROReadStrob, 1'b0);
        RODone = 1'b1;                             // real completion
        step();
        RODone = 1'b0;
        strobe_exp++;
        check("spur_real_strob", ROReadStrob, 1'b1);
        step(); step();

        // Reset while in WAIT_DONE with 3 entries queued.
        request(8'h40); step();
        request(8'h41); step();
        request(8'h42); step();                    // START for 0x40
        request(8'h43); step();
        L1Req = 1'b0;
        check("rst_mid_count3", QueueCount, 4'd3);
        SoftReset = 1'b1;
        RODone = 1'b1;                             // reset has priority
        step();
        SoftReset = 1'b0;
        sb.delete();
        check_reset_state("rst_mid");
        step();
        RODone = 1'b0;
        check("rst_mid_no_strob", ROReadStrob, 1'b0);
        step();
        check("rst_mid_no_strob2", ROReadStrob, 1'b0);
        check("rst_mid_no_start", ROStart, 1'b0);

        // L0ID comparison on the start edge.
        L0ID_Local = 8'h05;
        request(8'h06);
        step();
        L1Req = 1'b0;
        check("mm_before", L0IDMismatch, 1'b0);
        step();
        check("mm_start", ROStart, 1'b1);
        check("mm_set", L0IDMismatch, EXP_MM);
        ClearFlags = 1'b1;
        step();
        ClearFlags = 1'b0;
        check("mm_cleared", L0IDMismatch, 1'b0);
        RODone = 1'b1;
        step();
        RODone = 1'b0;
        strobe_exp++;
        check("mm_strob", ROReadStrob, 1'b1);
        step(); step();
        check("final_sb_empty", sb.size(), 0);
        check("final_strobes", strobe_seen, strobe_exp);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
